// File: rtl/divider_rst_52b26b.sv
// divider_rst_52b26b
// Unsigned restoring divider: a 2*WIDTH-bit dividend divided by a WIDTH-bit
// divisor, one quotient bit per clock, MSB first.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        request, sampled only while idle
//   dividend     2*WIDTH-bit unsigned dividend, captured on the accepting edge
//   divisor      WIDTH-bit unsigned divisor, captured on the accepting edge
//   busy         operation in progress (registered)
//   done         one-cycle completion pulse (registered)
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  divisor was zero (valid with done, held)
//   overflow     quotient does not fit in WIDTH bits (valid with done, held)
//
// Configuration macro: DIV_FAST_EXCEPTION_EN
//   When defined, an overflowing request skips the iterations and goes
//   straight to the finish state. Results are identical either way.

module divider_rst_52b26b #(
  parameter int WIDTH = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              state_r;
  logic [CW-1:0]       cnt_r;
  logic [WIDTH:0]      prem_r;     // partial remainder
  logic [WIDTH-1:0]    dvd_lo_r;   // low dividend bits still to be shifted in
  logic [WIDTH-1:0]    lo_keep_r;  // untouched low dividend, used on overflow
  logic [WIDTH-1:0]    dvs_r;
  logic [WIDTH-1:0]    quot_r;
  logic                ovf_r;
  logic                dbz_r;

  logic                ovf_s;
  logic                dbz_s;
  logic [WIDTH+1:0]    shifted_s;
  logic [WIDTH+1:0]    diff_s;
  logic                keep_s;
  logic [WIDTH:0]      next_prem_s;

  // Exception flags decoded straight from the operand inputs at the accepting edge.
  always_comb begin
    dbz_s = (divisor == {WIDTH{1'b0}});
    ovf_s = (dividend[2*WIDTH-1:WIDTH] >= divisor);
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  // prem_r stays below the divisor for valid operations, so its top bit is 0 and
  // the sign of the (WIDTH+2)-bit difference is a reliable borrow.
  always_comb begin
    shifted_s   = {prem_r, dvd_lo_r[WIDTH-1]};
    diff_s      = shifted_s - {2'b00, dvs_r};
    keep_s      = ~diff_s[WIDTH+1];
    if (keep_s) begin
      next_prem_s = diff_s[WIDTH:0];
    end else begin
      next_prem_s = shifted_s[WIDTH:0];
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      prem_r      <= {(WIDTH+1){1'b0}};
      dvd_lo_r    <= {WIDTH{1'b0}};
      lo_keep_r   <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      quot_r      <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // On overflow the upper half may not fit below the divisor, so
            // the iterations run on a cleared remainder; FIN overrides the result.
            prem_r    <= ovf_s ? {(WIDTH+1){1'b0}} : {1'b0, dividend[2*WIDTH-1:WIDTH]};
            dvd_lo_r  <= dividend[WIDTH-1:0];
            lo_keep_r <= dividend[WIDTH-1:0];
            dvs_r     <= divisor;
            quot_r    <= {WIDTH{1'b0}};
            ovf_r     <= ovf_s;
            dbz_r     <= dbz_s;
            cnt_r     <= {CW{1'b0}};
            busy      <= 1'b1;
`ifdef DIV_FAST_EXCEPTION_EN
            state_r   <= ovf_s ? FIN : RUN;
`else
            state_r   <= RUN;
`endif
          end
        end
        RUN: begin
          prem_r   <= next_prem_s;
          dvd_lo_r <= {dvd_lo_r[WIDTH-2:0], 1'b0};
          quot_r   <= {quot_r[WIDTH-2:0], keep_s};
          cnt_r    <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          quotient    <= ovf_r ? {WIDTH{1'b1}} : quot_r;
          remainder   <= ovf_r ? lo_keep_r : prem_r[WIDTH-1:0];
          overflow    <= ovf_r;
          div_by_zero <= dbz_r;
          done        <= 1'b1;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_rst_52b26b.sv
// Directed self-checking bench for divider_rst_52b26b.
// Latency is counted in rising edges from the accepting edge to the edge that
// raises done. With DIV_FAST_EXCEPTION_EN, an exception raises done on the
// first edge after acceptance (done is high in the cycle after E1).

module tb_divider_rst_52b26b;

  localparam int W = 26;
  localparam int NOM_LAT = 27;
`ifdef DIV_FAST_EXCEPTION_EN
  localparam int EXC_LAT = 1;
`else
  localparam int EXC_LAT = 27;
`endif

  logic             clk;
  logic             reset;
  logic             start;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic             busy;
  logic             done;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             div_by_zero;
  logic             overflow;

  int n_cmp;
  int n_bad;

  divider_rst_52b26b #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; optionally pokes an extra start at edge 10 that must be ignored.
  task automatic run_op(input string tag, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz,
                        input logic eovf, input int elat, input logic [W-1:0] prev_q,
                        input logic inject);
    int k;
    int pulses;
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = W'($urandom);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    k = 0;
    pulses = 0;
    while (k < 100) begin
      k++;
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        break;
      end else if (k == 1) begin
        chk({tag, "_held_q"}, 64'(quotient), 64'(prev_q));
      end
      if (inject && k == 9) begin
        start    = 1'b1;
        dividend = 52'd5;
        divisor  = 26'd1;
      end else if (inject && k == 10) begin
        start    = 1'b0;
      end
    end
    chk({tag, "_lat"}, 64'(k), 64'(elat));
    chk({tag, "_q"}, 64'(quotient), 64'(eq));
    chk({tag, "_r"}, 64'(remainder), 64'(er));
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
    chk({tag, "_ovf"}, 64'(overflow), 64'(eovf));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk({tag, "_pulses"}, 64'(pulses), 64'd1);
    chk({tag, "_q_hold"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    logic [2*W-1:0] big;
    int stray;
    n_cmp = 0;
    n_bad = 0;
    reset    = 1'b0;
    start    = 1'b0;
    dividend = 52'd0;
    divisor  = 26'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_q", 64'(quotient), 64'd0);
    chk("rst_r", 64'(remainder), 64'd0);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);

    // Reset wins over start on the same edge.
    @(negedge clk);
    start    = 1'b1;
    dividend = 52'd100;
    divisor  = 26'd7;
    @(posedge clk);
    #1;
    chk("rst_prio_busy", 64'(busy), 64'd0);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_prio_idle", 64'(busy), 64'd0);

    run_op("basic", 52'd100, 26'd7, 26'd14, 26'd2, 1'b0, 1'b0, NOM_LAT, 26'd0, 1'b0);

    big = 52'h3FFFFFF * 52'h3FFFFFF + 52'h3FFFFFE;
    run_op("maxq", big, 26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFE, 1'b0, 1'b0, NOM_LAT, 26'd14, 1'b0);

    run_op("dbz", 52'h123, 26'd0, 26'h3FFFFFF, 26'h123, 1'b1, 1'b1, EXC_LAT, 26'h3FFFFFF, 1'b0);

    big = 52'd1 << 51;
    run_op("ovf", big, 26'd1, 26'h3FFFFFF, 26'd0, 1'b0, 1'b1, EXC_LAT, 26'h3FFFFFF, 1'b0);

    run_op("ign_start", 52'd1000, 26'd10, 26'd100, 26'd0, 1'b0, 1'b0, NOM_LAT, 26'h3FFFFFF, 1'b1);

    // Reset in the middle of a run aborts it without a done pulse.
    @(negedge clk);
    dividend = 52'd100;
    divisor  = 26'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_q", 64'(quotient), 64'd0);
    chk("abort_r", 64'(remainder), 64'd0);
    chk("abort_flags", 64'({div_by_zero, overflow}), 64'd0);
    stray = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    chk("abort_no_done", 64'(stray), 64'd0);

    run_op("after_abort", 52'd100, 26'd7, 26'd14, 26'd2, 1'b0, 1'b0, NOM_LAT, 26'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
